// File: rtl/aes_dp_pkg.sv
// Shared AES types, round count and GF(2^8)/state-permutation helper functions.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable. AES_DP_KEY256_EN selects 14 rounds (AES-256) instead of 10.
package aes_dp_pkg;

`ifdef AES_DP_KEY256_EN
  localparam int NR = 14;
`else
  localparam int NR = 10;
`endif

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_t;

  // Byte 0 sits in the most significant byte, so a 128-bit block maps directly.
  typedef logic [0:15][7:0] aes_state_t;
  typedef logic [0:3][7:0]  aes_col_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      res = gmul(res, sq);
    end
    return res;
  endfunction

  function automatic aes_col_t mix_col(input aes_col_t c);
    aes_col_t o;
    for (int r = 0; r < 4; r++) begin
      o[r] = gmul(c[r], 8'h02) ^ gmul(c[(r + 1) % 4], 8'h03) ^ c[(r + 2) % 4] ^ c[(r + 3) % 4];
    end
    return o;
  endfunction

  function automatic aes_col_t inv_mix_col(input aes_col_t c);
    aes_col_t o;
    for (int r = 0; r < 4; r++) begin
      o[r] = gmul(c[r], 8'h0e) ^ gmul(c[(r + 1) % 4], 8'h0b) ^
             gmul(c[(r + 2) % 4], 8'h0d) ^ gmul(c[(r + 3) % 4], 8'h09);
    end
    return o;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    aes_col_t   col;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[r] = s[4 * c + r];
      col = mix_col(col);
      for (int r = 0; r < 4; r++) o[4 * c + r] = col[r];
    end
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    aes_col_t   col;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[r] = s[4 * c + r];
      col = inv_mix_col(col);
      for (int r = 0; r < 4; r++) o[4 * c + r] = col[r];
    end
    return o;
  endfunction

  // Row r rotates left by r columns; byte 4c+r is s[r][c].
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) o[4 * c + r] = s[4 * ((c + r) % 4) + r];
    end
    return o;
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) o[4 * c + r] = s[4 * ((c - r + 4) % 4) + r];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// Block-level valid/ready bundle between a block source/sink and the round engine.
// Latency: wires only.
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the result side.
interface aes_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_decrypt, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_decrypt, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_sbox_dual.sv
// Forward/inverse AES S-box sharing one GF(2^8) inverter; enc_sel=1 selects forward.
// Latency: combinational.
// Backpressure: none.
module aes_sbox_dual
  import aes_dp_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       enc_sel,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  logic [7:0] pre;
  logic [7:0] inv;

  // Inverse direction applies the inverse affine map before inversion, forward applies it after.
  always_comb begin
    pre      = enc_sel ? in_byte
                       : (rotl8(in_byte, 1) ^ rotl8(in_byte, 3) ^ rotl8(in_byte, 6) ^ 8'h05);
    inv      = gf_inv(pre);
    out_byte = enc_sel ? (inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63)
                       : inv;
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES block engine (encrypt/decrypt), BYTES_PER_CYCLE S-box lanes; AES_DP_KEY256_EN gives 14 rounds.
// Latency: out_valid rises NR*(16/BYTES_PER_CYCLE+1) cycles after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; abort flushes to IDLE.
module aes_round_engine
  import aes_dp_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  aes_round_engine_if.slave       bus,
  output logic [3:0]              rk_idx,
  input  logic [127:0]            rk,
  output logic                    busy
);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bpc_illegal
    $error("aes_round_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int         SUBC      = 16 / BYTES_PER_CYCLE;
  localparam logic [3:0] SUBC_LAST = 4'(SUBC - 1);
  localparam logic [3:0] NR_Q      = 4'(NR);

  fsm_t       fsm_q, fsm_d;
  aes_state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] lane_cnt_q, lane_cnt_d;
  logic       mode_q, mode_d;
  logic [3:0] rk_idx_q;

  aes_state_t mix_res;
  logic [3:0] lane_base;
  logic [7:0] sb_in  [BYTES_PER_CYCLE];
  logic [7:0] sb_out [BYTES_PER_CYCLE];

  // With 16 lanes the counter never leaves 0, so truncating the lane stride is harmless.
  assign lane_base = 4'(lane_cnt_q * 4'(BYTES_PER_CYCLE));

  // Select the slice of bytes handled by the S-box lanes this cycle.
  always_comb begin
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      sb_in[i] = state_q[lane_base + 4'(i)];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    aes_sbox_dual u_sbox (
      .in_byte  (sb_in[g]),
      .enc_sel  (~mode_q),
      .out_byte (sb_out[g])
    );
  end

  // One MIX step; InvSubBytes/InvShiftRows commute so the earlier SUB pass stays exact.
  always_comb begin
    if (mode_q) begin
      mix_res = inv_shift_rows(state_q) ^ rk;
      if (round_q != NR_Q) mix_res = inv_mix_columns(mix_res);
    end else begin
      mix_res = shift_rows(state_q);
      if (round_q != NR_Q) mix_res = mix_columns(mix_res);
      mix_res = mix_res ^ rk;
    end
  end

  // Next-state, key index and datapath updates; abort overrides everything.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    round_d    = round_q;
    lane_cnt_d = lane_cnt_q;
    mode_d     = mode_q;
    rk_idx     = rk_idx_q;
    case (fsm_q)
      IDLE: begin
        rk_idx = bus.in_decrypt ? NR_Q : 4'd0;
        if (bus.in_valid) begin
          state_d    = bus.in_data ^ rk;
          mode_d     = bus.in_decrypt;
          round_d    = 4'd1;
          lane_cnt_d = 4'd0;
          fsm_d      = SUB;
        end
      end
      SUB: begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
          state_d[lane_base + 4'(i)] = sb_out[i];
        end
        if (lane_cnt_q == SUBC_LAST) begin
          lane_cnt_d = 4'd0;
          fsm_d      = MIX;
        end else begin
          lane_cnt_d = lane_cnt_q + 4'd1;
        end
      end
      MIX: begin
        rk_idx  = mode_q ? (NR_Q - round_q) : round_q;
        state_d = mix_res;
        if (round_q == NR_Q) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = SUB;
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    if (abort) begin
      fsm_d      = IDLE;
      state_d    = state_q;
      round_d    = round_q;
      lane_cnt_d = lane_cnt_q;
      mode_d     = mode_q;
    end
  end

  // State and datapath registers; rk_idx_q keeps the last requested index between MIX cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      round_q    <= 4'd0;
      lane_cnt_q <= 4'd0;
      mode_q     <= 1'b0;
      rk_idx_q   <= 4'd0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      round_q    <= round_d;
      lane_cnt_q <= lane_cnt_d;
      mode_q     <= mode_d;
      rk_idx_q   <= rk_idx;
    end
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_data  = (fsm_q == DONE) ? state_q : '0;
  assign busy          = (fsm_q != IDLE);

endmodule
